// File: rtl/permutation_bot_dispatcher.sv
// Round-robin arbiter sharing one bot input FIFO among the permutation sub-generators.
// Each grant issues one FIFO read and later produces a load strobe aligned to the returning data.
module permutation_bot_dispatcher #(
    parameter int NUM_PERMUTATORS   = 3,
    parameter int FIFO_READ_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifoEmpty,
    output logic                       fifoReadRequest,
    input  logic                       fifoDataValid,
    input  logic [NUM_PERMUTATORS-1:0] botRequest,
    input  logic [NUM_PERMUTATORS-1:0] slowDown,
    output logic [NUM_PERMUTATORS-1:0] loadBot,
    output logic                       loadBotValid,
    output logic [NUM_PERMUTATORS-1:0] pendingMask,
    output logic                       requestOverflow
);

    localparam int N  = NUM_PERMUTATORS;
    localparam int L  = FIFO_READ_LATENCY;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  pending;
    logic [N-1:0]  eligible;
    logic [N-1:0]  grant_vec;
    logic [N-1:0]  pipe [0:L];
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] rr_next;
    logic [PW-1:0] sel;
    logic          grant_any;
    int            scan;

    assign eligible = pending & ~slowDown;

    // Scan starts at the round-robin pointer and wraps modulo N.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = 0;
        sel       = '0;
        for (int k = 0; k < N; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= N) scan = scan - N;
            sel = PW'(scan);
            if (!grant_any && !fifoEmpty && eligible[sel]) begin
                grant_any      = 1'b1;
                grant_idx      = sel;
                grant_vec[sel] = 1'b1;
            end
        end
    end

    assign rr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending         <= '0;
            rr_ptr          <= '0;
            fifoReadRequest <= 1'b0;
            requestOverflow <= 1'b0;
            for (int k = 0; k <= L; k++) pipe[k] <= '0;
        end else begin
            pending         <= (pending & ~grant_vec) | (botRequest & ~slowDown);
            fifoReadRequest <= grant_any;
            if (grant_any) rr_ptr <= rr_next;
            if (|(botRequest & pending & ~grant_vec)) requestOverflow <= 1'b1;
            pipe[0] <= grant_vec;
            for (int k = 1; k <= L; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Stage 0 holds the grant during the read-request cycle, so stage L meets the data.
    assign loadBot      = pipe[L];
    assign loadBotValid = fifoDataValid & (|pipe[L]);
    assign pendingMask  = pending;

endmodule
